iter_muldiv: RTL and testbench
==============================

ITER_MULDIV -- requirements
Module: iter_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand and result width; legal values are even integers >= 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, with asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1, which requests an operation and is sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, the operation selector: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 The block SHALL have ports operand_1 and operand_2, input, WIDTH each: multiplicand/multiplier or dividend/divisor.
REQ-007 The block SHALL have port cancel, input, 1, a pipeline flush that aborts any operation in progress.
REQ-008 The block SHALL have port busy, output, 1, high from the accepting edge until the result is delivered or the operation is cancelled.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse indicating that hi/lo are valid.
REQ-010 The block SHALL have ports hi and lo, output, WIDTH each; MUL gives the upper and lower product halves, DIV gives remainder and quotient.
REQ-011 The block SHALL have port div_zero, output, 1, which is high with done when the divisor was 0, and low otherwise.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC, FIXUP and DONE; reset enters IDLE.
REQ-013 IDLE SHALL accept an operation when start=1 and cancel=0: it latches op, the operand magnitudes (two's-complement absolute value for signed ops) and the result signs, then moves to CALC.
REQ-014 start SHALL be ignored while busy=1, and operands are not re-sampled.
REQ-015 CALC SHALL run exactly WIDTH cycles, counted by a modulo counter of $clog2(WIDTH)+1 bits: radix-2 shift-add for MUL, restoring shift-subtract for DIV, one bit per cycle; then CALC moves to FIXUP.
REQ-016 FIXUP SHALL negate the results for signed ops: MUL negates the 2*WIDTH product if the operand signs differ; DIV negates the quotient if the signs differ and gives the remainder the sign of the dividend; FIXUP then moves to DONE.
REQ-017 DONE SHALL register hi/lo, assert done for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-018 Latency SHALL be fixed: done is high in the cycle after edge WIDTH+2, counting the accepting edge as edge 0.
REQ-019 Division by zero SHALL skip CALC (IDLE->FIXUP->DONE, done after edge 2) with lo = all ones, hi = operand_1 unmodified, and div_zero=1.
REQ-020 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0, with no flag and no trap.
REQ-021 cancel=1 in any state SHALL return the FSM to IDLE on the next edge, with busy=0, no done pulse, and hi/lo/div_zero unchanged.
REQ-022 start and cancel high in the same IDLE cycle SHALL resolve with cancel winning and the operation not accepted.
REQ-023 hi, lo and div_zero SHALL hold their last delivered values until the next DONE.
REQ-024 A new start SHALL be accepted in the cycle immediately after done (back-to-back), giving throughput of one operation per WIDTH+3 cycles.
REQ-025 MUL SHALL produce the full 2*WIDTH product with no overflow indication.

Reset
REQ-026 rst_n=0 SHALL immediately force the state to IDLE and busy, done, div_zero, hi, lo and the counter to 0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the operation; after release, no done pulse is issued until a new start.

Verification (WIDTH=32)
REQ-028 MULT -3 (FFFFFFFD) x 5 SHALL give hi=FFFFFFFF and lo=FFFFFFF1, with done high after edge 34 and busy high for edges 0..33.
REQ-029 MULTU FFFFFFFF x FFFFFFFF SHALL give hi=FFFFFFFE and lo=00000001; a back-to-back DIVU 100/7 started the cycle after done SHALL give lo=0000000E and hi=00000002.
REQ-030 DIV -7 / 2 SHALL give lo=FFFFFFFD and hi=FFFFFFFF; DIV 80000000 / FFFFFFFF SHALL give lo=80000000 and hi=00000000.
REQ-031 DIVU 7 / 0 SHALL give div_zero=1, lo=FFFFFFFF and hi=00000007, with done after edge 2; a following DIVU 7/1 SHALL clear div_zero.
REQ-032 A MULTU with cancel at edge 10 SHALL give busy=0 after edge 11, no done, and hi/lo equal to the previous results; a start in the same cycle as cancel SHALL be ignored.
REQ-033 rst_n pulsed low mid-CALC SHALL clear all outputs to 0 asynchronously, with no done afterwards; a fresh MULT 6 x 7 SHALL then give lo=0000002A and hi=0.

Source files
------------

// File: rtl/iter_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add MUL, restoring DIV.
// Fixed latency of WIDTH+3 cycles, with cancel and divide-by-zero bypass.
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic             accept;
  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic             zero_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_neg;

  assign op_signed = ~op[0];
  assign a_neg     = op_signed & operand_1[WIDTH-1];
  assign b_neg     = op_signed & operand_2[WIDTH-1];
  assign a_mag     = a_neg ? -operand_1 : operand_1;
  assign b_mag     = b_neg ? -operand_2 : operand_2;
  assign zero_div  = op[1] & (operand_2 == '0);
  assign accept    = (state == IDLE) & start & ~cancel;

  // acc_lo holds the multiplier (shifted out) or the dividend (shifted in)
  assign mul_sum   = {1'b0, acc_hi}
                   + (acc_lo[0] ? {1'b0, mag_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mag_b};
  assign div_ge    = div_shift >= {1'b0, mag_b};
  assign prod      = {acc_hi, acc_lo};
  assign prod_neg  = -prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state_nxt = zero_div ? FIXUP : CALC;
        end
        CALC: begin
          if (cnt == LAST) state_nxt = FIXUP;
        end
        FIXUP:   state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dz     <= zero_div;
      unique case (1'b1)
        zero_div: begin
          acc_hi <= operand_1;
          acc_lo <= '1;
          mag_b  <= '0;
        end
        op[1] & ~zero_div: begin
          acc_hi <= '0;
          acc_lo <= a_mag;
          mag_b  <= b_mag;
        end
        ~op[1]: begin
          acc_hi <= '0;
          acc_lo <= b_mag;
          mag_b  <= a_mag;
        end
        default: begin
          acc_hi <= '0;
          acc_lo <= '0;
          mag_b  <= '0;
        end
      endcase
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      if (is_div) begin
        acc_hi <= div_ge ? div_diff[WIDTH-1:0]
                         : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
      end else begin
        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
      end
    end else if (state == FIXUP && !dz) begin
      if (is_div) begin
        acc_lo <= neg_q ? -acc_lo : acc_lo;
        acc_hi <= neg_r ? -acc_hi : acc_hi;
      end else if (neg_q) begin
        {acc_hi, acc_lo} <= prod_neg;
      end
    end
  end

  // a cancel landing on DONE suppresses delivery entirely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= (state == DONE) & ~cancel;
      if (state == DONE && !cancel) begin
        hi       <= acc_hi;
        lo       <= acc_lo;
        div_zero <= dz;
      end
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Scoreboard bench for iter_muldiv: directed vectors plus random ops
// against a plain-arithmetic 64-bit reference model.
module tb_iter_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cancel = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] operand_1 = '0;
  logic [W-1:0] operand_2 = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .operand_1(operand_1),
    .operand_2(operand_2),
    .cancel(cancel),
    .busy(busy),
    .done(done),
    .hi(hi),
    .lo(lo),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;
  logic         last_dz = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    e.dz = 1'b0;
    e.due = 0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'd0: begin
        p = sa * sb;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'd1: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          e.hi = a;
          e.lo = '1;
          e.dz = 1'b1;
        end else begin
          if (o == 2'd2) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
        check("latency", cyc, mon_e.due);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Called at a negedge with the DUT idle (or showing done).
  task automatic run_op(input logic [1:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    exp_t e;
    bit seen;
    bit busy_ok;
    e = model(o, a, b);
    op = o;
    operand_1 = a;
    operand_2 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.due = cyc + ((o[1] && b == '0) ? 2 : W + 2);
    sb_q.push_back(e);
    last_hi = e.hi;
    last_lo = e.lo;
    last_dz = e.dz;
    start = 1'b0;
    seen = 0;
    busy_ok = 1;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (!busy) busy_ok = 0;
      start = (i == 3);
      op = 2'($urandom);
      operand_1 = $urandom;
      operand_2 = $urandom;
    end
    start = 1'b0;
    check("busy_held", busy_ok, 1);
    check("done_seen", seen, 1);
    if (!seen) sb_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dz", div_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'd0, 32'hFFFFFFFD, 32'd5);
    check("mult_m3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(2'd3, 32'd100, 32'd7);
    check("divu_100_7", {hi, lo}, 64'h00000002_0000000E);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2);
    check("div_m7_2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_min_m1", {hi, lo}, 64'h00000000_80000000);
    run_op(2'd3, 32'd7, 32'd0);
    check("divu_by0", {div_zero, hi, lo}, {1'b1, 64'h00000007_FFFFFFFF});
    run_op(2'd3, 32'd7, 32'd1);
    check("divu_7_1", {div_zero, hi, lo}, {1'b0, 64'h00000000_00000007});

    // cancel mid-CALC
    repeat (2) @(negedge clk);
    op = 2'd1;
    operand_1 = $urandom;
    operand_2 = $urandom;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    cancel = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("cancel_busy", busy, 0);
    cancel = 1'b0;
    start = 1'b0;
    repeat (W + 5) @(negedge clk);
    check("cancel_hold", {div_zero, hi, lo}, {last_dz, last_hi, last_lo});

    // start and cancel together in IDLE
    op = 2'd0;
    operand_1 = 32'd3;
    operand_2 = 32'd3;
    start = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    check("idle_cancel_busy", busy, 0);
    start = 1'b0;
    cancel = 1'b0;
    repeat (W + 5) @(negedge clk);
    check("idle_cancel_hold", {hi, lo}, {last_hi, last_lo});

    // asynchronous reset mid-CALC
    op = 2'd0;
    operand_1 = 32'd12345;
    operand_2 = 32'd678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_outs", {busy, done, div_zero, hi, lo}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    last_hi = '0;
    last_lo = '0;
    repeat (W + 5) @(negedge clk);
    check("arst_hold", {hi, lo}, 64'd0);
    run_op(2'd0, 32'd6, 32'd7);
    check("mult_6x7", {hi, lo}, 64'h00000000_0000002A);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
